// File: rtl/fpa_pkg.sv
// Shared widths, limits and the stage-1 payload type for the FP adder normalize/round stage.
// Optional build macro used by the stage: FPA_DENORM_EN (gradual underflow instead of flush-to-zero).
package fpa_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int FRAC_W   = 28;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    // Normalized fraction: [26] hidden bit, [25:3] mantissa, [2:0] guard/round/sticky.
    typedef struct packed {
        logic               sign;
        logic signed [9:0]  exp;
        logic [26:0]        frac;
        logic               zero;
    } s1_payload_t;

endpackage

// File: rtl/fpa_norm_round_if.sv
// Stream bundle between the fraction add/sub stage, this normalize/round stage and its consumer.
// master = the environment around the stage, slave = fpa_norm_round itself.
interface fpa_norm_round_if;
    import fpa_pkg::*;

    // Both sides use plain valid/ready: a beat moves on a rising edge where valid & ready
    // are both 1; a producer holds valid and its payload stable until that edge.
    logic               in_valid;
    logic               in_ready;
    logic [FRAC_W-1:0]  in_frac;
    logic [EXP_W-1:0]   in_exp;
    logic               in_sign;

    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_result;
    logic               out_overflow;
    logic               out_underflow;
    logic               out_inexact;

    modport master (
        output in_valid, in_frac, in_exp, in_sign, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
    );

    modport slave (
        input  in_valid, in_frac, in_exp, in_sign, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
    );

endinterface

// File: rtl/fpa_lzc27.sv
// Combinational leading-zero counter over a 27-bit word; reports 27 when the word is all zero.
module fpa_lzc27 (
    input  logic [26:0] value,
    output logic [4:0]  count
);

    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (value[i]) begin
                count = 5'(26 - i);
            end
        end
    end

endmodule

// File: rtl/fpa_norm_round.sv
// Normalize-and-round stage of the binary32 adder: 2-entry valid/ready pipeline, RNE rounding.
// Build macro FPA_DENORM_EN selects gradual underflow; default flushes tiny results to signed zero.
module fpa_norm_round
    import fpa_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    fpa_norm_round_if.slave bus
);

    logic        s1_valid;
    logic        s2_valid;
    logic        s1_load;
    logic        s2_load;

    s1_payload_t s1_d;
    s1_payload_t s1_q;
    logic [4:0]  lz;

    logic [31:0] res_d;
    logic [31:0] res_q;
    logic        ovf_d, unf_d, inx_d;
    logic        ovf_q, unf_q, inx_q;

    logic              tiny;
    logic [26:0]       f_r;
    logic [23:0]       sig;
    logic              g_bit, r_bit, s_bit;
    logic              round_up;
    logic [24:0]       sum;
    logic signed [9:0] e_r;

`ifdef FPA_DENORM_EN
    logic [9:0]  sh_w;
    logic [4:0]  sh;
    logic [27:0] mask;
`endif

    // Stage advance: a register refills when it is empty or its content moves on this edge.
    assign s2_load = !s2_valid || bus.out_ready;
    assign s1_load = !s1_valid || s2_load;

    assign bus.in_ready      = s1_load;
    assign bus.out_valid     = s2_valid;
    assign bus.out_result    = res_q;
    assign bus.out_overflow  = ovf_q;
    assign bus.out_underflow = unf_q;
    assign bus.out_inexact   = inx_q;

    fpa_lzc27 u_lzc (
        .value (bus.in_frac[26:0]),
        .count (lz)
    );

    // Stage 1: bring the leading one to bit 26 of the fraction.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = bus.in_sign;
        s1_d.zero = (bus.in_frac == '0);
        if (bus.in_frac[27]) begin
            s1_d.frac = {bus.in_frac[27:2], bus.in_frac[1] | bus.in_frac[0]};
            s1_d.exp  = 10'(bus.in_exp) + 10'd1;
        end else begin
            s1_d.frac = bus.in_frac[26:0] << lz;
            s1_d.exp  = 10'(bus.in_exp) - 10'(lz);
        end
    end

    // Stage 2: denormalize if needed, round to nearest even, detect overflow, pack.
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = 1'b0;
        tiny  = (s1_q.exp <= 10'sd0);
        f_r   = s1_q.frac;
`ifdef FPA_DENORM_EN
        sh_w = 10'd1 - $unsigned(s1_q.exp);
        sh   = (sh_w > 10'd27) ? 5'd27 : sh_w[4:0];
        mask = (28'd1 << sh) - 28'd1;
        if (tiny) begin
            f_r = (s1_q.frac >> sh) | {26'd0, |(s1_q.frac & mask[26:0])};
        end
`endif
        sig      = f_r[26:3];
        g_bit    = f_r[2];
        r_bit    = f_r[1];
        s_bit    = f_r[0];
        round_up = g_bit & (r_bit | s_bit | sig[0]);
        sum      = {1'b0, sig} + {24'd0, round_up};
        // A carry out of the significand leaves sum[22:0] zero, i.e. 1.0 at the next exponent.
        e_r      = sum[24] ? (s1_q.exp + 10'sd1) : s1_q.exp;

        if (s1_q.zero) begin
            res_d = '0;
        end else if (tiny) begin
`ifdef FPA_DENORM_EN
            // Rounding into the hidden bit turns sum[23] into exponent field 1.
            res_d = {s1_q.sign, 7'd0, sum[23], sum[MAN_W-1:0]};
            inx_d = g_bit | r_bit | s_bit;
            unf_d = g_bit | r_bit | s_bit;
`else
            res_d = {s1_q.sign, 31'd0};
            inx_d = 1'b1;
            unf_d = 1'b1;
`endif
        end else if (e_r >= 10'(EXP_MAX)) begin
            res_d = {s1_q.sign, 8'hFF, 23'd0};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else begin
            res_d = {s1_q.sign, e_r[7:0], sum[MAN_W-1:0]};
            inx_d = g_bit | r_bit | s_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_load) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Output registers only change on a real load, so they stay put under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                res_q <= res_d;
                ovf_q <= ovf_d;
                unf_q <= unf_d;
                inx_q <= inx_d;
            end
        end
    end

endmodule

// File: tb/tb_fpa_norm_round.sv
// Directed bench for fpa_norm_round: hand-computed vectors, backpressure stream and reset checks.
// Expected tiny-result values follow FPA_DENORM_EN when the bench is built with it.
module tb_fpa_norm_round;
    import fpa_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fpa_norm_round_if bus ();

    fpa_norm_round dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Expected entries are {overflow, underflow, inexact, result}.
    logic [34:0] exp_q[$];
    logic [27:0] s_frac[3];
    logic [7:0]  s_exp[3];
    logic        s_sign[3];
    logic [34:0] s_out[3];

    function automatic logic [34:0] pk(input logic ovf, input logic unf, input logic inx,
                                       input logic [31:0] res);
        return {ovf, unf, inx, res};
    endfunction

    function automatic logic [34:0] observed();
        return {bus.out_overflow, bus.out_underflow, bus.out_inexact, bus.out_result};
    endfunction

    task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One isolated transaction with out_ready=1; result must appear exactly two cycles later.
    task automatic run_vec(input string tag, input logic [27:0] f, input logic [7:0] e,
                           input logic s, input logic [34:0] expv, input logic chk_unf);
        logic [34:0] obs;
        logic [34:0] want;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_frac  = f;
        bus.in_exp   = e;
        bus.in_sign  = s;
        #1;
        check({tag, " in_ready"}, 35'(bus.in_ready), 35'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, " early"}, 35'(bus.out_valid), 35'd0);
        @(negedge clk);
        check({tag, " out_valid"}, 35'(bus.out_valid), 35'd1);
        obs  = observed();
        want = expv;
        if (!chk_unf) begin
            obs[33]  = 1'b0;
            want[33] = 1'b0;
        end
        check(tag, obs, want);
    endtask

    // Offers s_* back to back while out_ready is low for the first `stall` cycles.
    task automatic stream(input string tag, input int stall, input int last_cyc);
        int idx = 0;
        int n_out = 0;
        int last = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.out_ready = (c >= stall);
            if (idx < 3) begin
                bus.in_valid = 1'b1;
                bus.in_frac  = s_frac[idx];
                bus.in_exp   = s_exp[idx];
                bus.in_sign  = s_sign[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                last = c;
                if (exp_q.size() > 0) begin
                    check({tag, " data"}, observed(), exp_q.pop_front());
                end
            end
            if (c >= 2 && c < stall) begin
                check({tag, " stall in_ready"}, 35'(bus.in_ready), 35'd0);
                check({tag, " held"}, observed(), s_out[0]);
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(s_out[idx]);
                idx++;
            end
            if (stall > 0 && c == stall - 1) begin
                check({tag, " accepts in stall"}, 35'(idx), 35'd2);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check({tag, " output count"}, 35'(n_out), 35'd3);
        check({tag, " last output cycle"}, 35'(last), 35'(last_cyc));
        check({tag, " queue empty"}, 35'(exp_q.size()), 35'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_frac   = '0;
        bus.in_exp    = '0;
        bus.in_sign   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset in_ready", 35'(bus.in_ready), 35'd1);
        check("reset out_valid", 35'(bus.out_valid), 35'd0);
        check("reset outputs", observed(), 35'd0);

        run_vec("one_plus_one", 28'h8000000, 8'd127, 1'b0, pk(0, 0, 0, 32'h40000000), 1'b1);
        run_vec("deep_cancel",  28'h0000008, 8'd127, 1'b0, pk(0, 0, 0, 32'h34000000), 1'b1);
        run_vec("tie_even",     28'h4000004, 8'd127, 1'b0, pk(0, 0, 1, 32'h3F800000), 1'b1);
        run_vec("tie_odd",      28'h400000C, 8'd127, 1'b0, pk(0, 0, 1, 32'h3F800002), 1'b1);
        run_vec("negative",     28'h4000000, 8'd127, 1'b1, pk(0, 0, 0, 32'hBF800000), 1'b1);
        run_vec("carry_sticky", 28'h8000003, 8'd127, 1'b0, pk(0, 0, 1, 32'h40000000), 1'b1);
        run_vec("round_carry",  28'h7FFFFFC, 8'd127, 1'b0, pk(0, 0, 1, 32'h40000000), 1'b1);
        run_vec("overflow",     28'h8000000, 8'd254, 1'b0, pk(1, 0, 1, 32'h7F800000), 1'b1);
        run_vec("round_ovf",    28'h7FFFFFC, 8'd254, 1'b1, pk(1, 0, 1, 32'hFF800000), 1'b1);
        run_vec("max_finite",   28'h7FFFFF8, 8'd254, 1'b0, pk(0, 0, 0, 32'h7F7FFFFF), 1'b1);
        run_vec("zero_neg",     28'h0000000, 8'd100, 1'b1, pk(0, 0, 0, 32'h00000000), 1'b1);
`ifdef FPA_DENORM_EN
        run_vec("tiny_half",    28'h2000000, 8'd1, 1'b0, pk(0, 0, 0, 32'h00400000), 1'b1);
        run_vec("tiny_neg",     28'h2000000, 8'd1, 1'b1, pk(0, 0, 0, 32'h80400000), 1'b1);
        run_vec("tiny_min",     28'h0000008, 8'd1, 1'b0, pk(0, 0, 0, 32'h00000001), 1'b1);
        run_vec("tiny_to_norm", 28'h3FFFFFE, 8'd1, 1'b0, pk(0, 0, 1, 32'h00800000), 1'b0);
`else
        run_vec("tiny_half",    28'h2000000, 8'd1, 1'b0, pk(0, 1, 1, 32'h00000000), 1'b1);
        run_vec("tiny_neg",     28'h2000000, 8'd1, 1'b1, pk(0, 1, 1, 32'h80000000), 1'b1);
        run_vec("tiny_min",     28'h0000008, 8'd1, 1'b0, pk(0, 1, 1, 32'h00000000), 1'b1);
        run_vec("tiny_to_norm", 28'h3FFFFFE, 8'd1, 1'b0, pk(0, 1, 1, 32'h00000000), 1'b1);
`endif

        // Full-rate stream, no backpressure.
        s_frac[0] = 28'h4000000; s_exp[0] = 8'd127; s_sign[0] = 1'b1; s_out[0] = pk(0, 0, 0, 32'hBF800000);
        s_frac[1] = 28'h0000008; s_exp[1] = 8'd127; s_sign[1] = 1'b0; s_out[1] = pk(0, 0, 0, 32'h34000000);
        s_frac[2] = 28'h8000003; s_exp[2] = 8'd127; s_sign[2] = 1'b0; s_out[2] = pk(0, 0, 1, 32'h40000000);
        stream("thruput", 0, 4);

        // Four cycles of backpressure with three back-to-back offers.
        s_frac[0] = 28'h8000000; s_exp[0] = 8'd127; s_sign[0] = 1'b0; s_out[0] = pk(0, 0, 0, 32'h40000000);
        s_frac[1] = 28'h0000000; s_exp[1] = 8'd127; s_sign[1] = 1'b1; s_out[1] = pk(0, 0, 0, 32'h00000000);
        s_frac[2] = 28'h400000C; s_exp[2] = 8'd127; s_sign[2] = 1'b0; s_out[2] = pk(0, 0, 1, 32'h3F800002);
        stream("backpressure", 4, 6);

        // Reset while a transaction is in flight must drop it.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_frac  = 28'h8000000;
        bus.in_exp   = 8'd127;
        bus.in_sign  = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midreset in_ready", 35'(bus.in_ready), 35'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midreset no output", 35'(bus.out_valid), 35'd0);
        end
        check("midreset outputs", observed(), 35'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
